// File: rtl/hiscore_uploader.sv
// hiscore_uploader: read side of the HPS ioctl file channel. On an upload with
// ioctl_index == INDEX it halts the core and serves NVRAM bytes to hps_io.
// Optional macro UPLOAD_CSUM_EN: address SIZE returns an 8-bit sum of the RAM
// bytes served this session, and completion moves from SIZE-1 to SIZE.
module hiscore_uploader #(
    parameter logic [7:0]  INDEX   = 8'd4,
    parameter int unsigned AW      = 10,
    parameter int unsigned SIZE    = 512,
    parameter int unsigned RAM_LAT = 2
) (
    input  logic          clk_sys,
    input  logic          RESET,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          pause_req,
    input  logic          pause_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [7:0]    ram_dout,
    output logic          done
);

    localparam int unsigned LAT_W  = 3;
    localparam logic [24:0] SIZE_A = 25'(SIZE);
`ifdef UPLOAD_CSUM_EN
    localparam logic [24:0] LAST_A = 25'(SIZE);
`else
    localparam logic [24:0] LAST_A = 25'(SIZE - 1);
`endif

    typedef enum logic [1:0] {IDLE, HALT, SERVE, FETCH} state_t;

    state_t            state_q, state_d;
    logic              sess_q;
    logic [24:0]       addr_q, addr_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [7:0]        din_q, din_d;
    logic              pause_q, pause_d;
    logic [AW-1:0]     ram_addr_q, ram_addr_d;
    logic              ram_rd_q, ram_rd_d;
    logic              done_q, done_d;
    logic              served_q, served_d;
    logic              session_c, rise_c, in_range_c, wait_c;
    logic [7:0]        oor_byte_c;
`ifdef UPLOAD_CSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    assign session_c  = ioctl_upload && (ioctl_index == INDEX);
    assign rise_c     = session_c && !sess_q;
    assign in_range_c = (addr_q < SIZE_A);

`ifdef UPLOAD_CSUM_EN
    assign oor_byte_c = (addr_q == SIZE_A) ? sum_q : 8'hFF;
`else
    assign oor_byte_c = 8'hFF;
`endif

    // Next-state, stall and datapath updates; an upload drop overrides everything.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        lat_d      = lat_q;
        din_d      = din_q;
        pause_d    = pause_q;
        ram_addr_d = ram_addr_q;
        ram_rd_d   = 1'b0;
        done_d     = 1'b0;
        served_d   = served_q;
        wait_c     = 1'b0;
`ifdef UPLOAD_CSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            HALT, FETCH: wait_c = 1'b1;
            SERVE:       wait_c = ioctl_rd;
            default:     wait_c = 1'b0;
        endcase

        if ((state_q != IDLE) && !ioctl_upload) begin
            state_d = IDLE;
            pause_d = 1'b0;
            done_d  = served_q && (state_q != FETCH);
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise_c) begin
                        state_d  = HALT;
                        pause_d  = 1'b1;
                        served_d = 1'b0;
`ifdef UPLOAD_CSUM_EN
                        sum_d    = 8'h00;
`endif
                    end
                end
                HALT: begin
                    if (pause_ack) state_d = SERVE;
                end
                SERVE: begin
                    if (ioctl_rd) begin
                        addr_d  = ioctl_addr;
                        lat_d   = LAT_W'(1);
                        state_d = FETCH;
                        if (ioctl_addr < SIZE_A) begin
                            ram_rd_d   = 1'b1;
                            ram_addr_d = ioctl_addr[AW-1:0];
                        end
                    end
                end
                FETCH: begin
                    if (!in_range_c || (lat_q == LAT_W'(RAM_LAT))) begin
                        state_d = SERVE;
                        din_d   = in_range_c ? ram_dout : oor_byte_c;
                        if (addr_q == LAST_A) served_d = 1'b1;
`ifdef UPLOAD_CSUM_EN
                        if (in_range_c) sum_d = sum_q + ram_dout;
`endif
                    end else begin
                        lat_d = lat_q + LAT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state_q    <= IDLE;
            sess_q     <= 1'b0;
            addr_q     <= '0;
            lat_q      <= '0;
            din_q      <= 8'h00;
            pause_q    <= 1'b0;
            ram_addr_q <= '0;
            ram_rd_q   <= 1'b0;
            done_q     <= 1'b0;
            served_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sess_q     <= session_c;
            addr_q     <= addr_d;
            lat_q      <= lat_d;
            din_q      <= din_d;
            pause_q    <= pause_d;
            ram_addr_q <= ram_addr_d;
            ram_rd_q   <= ram_rd_d;
            done_q     <= done_d;
            served_q   <= served_d;
        end
    end

`ifdef UPLOAD_CSUM_EN
    // Running modulo-256 sum of RAM bytes served this session.
    always_ff @(posedge clk_sys) begin
        if (RESET) sum_q <= 8'h00;
        else       sum_q <= sum_d;
    end
`endif

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_c;
    assign pause_req  = pause_q;
    assign ram_addr   = ram_addr_q;
    assign ram_rd     = ram_rd_q;
    assign done       = done_q;

endmodule

// File: tb/tb_hiscore_uploader.sv
// Self-checking bench for hiscore_uploader: directed scenarios plus randomized
// sessions, compared each cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_hiscore_uploader;

    localparam int unsigned AW   = 10;
    localparam int unsigned SIZE = 512;
    localparam int unsigned LAT  = 2;
    localparam logic [7:0]  IDX  = 8'd4;
`ifdef UPLOAD_CSUM_EN
    localparam int LAST = SIZE;
`else
    localparam int LAST = SIZE - 1;
`endif

    logic          clk_sys = 1'b0;
    logic          RESET = 1'b1;
    logic          ioctl_upload = 1'b0;
    logic [7:0]    ioctl_index = 8'd0;
    logic          ioctl_rd = 1'b0;
    logic [24:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic          pause_req;
    logic          pause_ack = 1'b0;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic [7:0]    ram_dout;
    logic          done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_sys = ~clk_sys;

    hiscore_uploader #(.INDEX(IDX), .AW(AW), .SIZE(SIZE), .RAM_LAT(LAT)) dut (
        .clk_sys(clk_sys), .RESET(RESET), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .pause_req(pause_req),
        .pause_ack(pause_ack), .ram_addr(ram_addr), .ram_rd(ram_rd),
        .ram_dout(ram_dout), .done(done)
    );

    // RAM: data for a read strobed in cycle c is valid only in cycle c+LAT-1 (LAT=2).
    logic [7:0]    mem [0:(1<<AW)-1];
    logic          rv_q = 1'b0;
    logic [AW-1:0] ra_q = '0;
    logic [7:0]    junk_q = 8'h5A;
    always @(posedge clk_sys) begin
        rv_q   <= ram_rd;
        ra_q   <= ram_addr;
        junk_q <= 8'($urandom);
    end
    assign ram_dout = rv_q ? mem[ra_q] : junk_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] expect_byte(input logic [24:0] a, input logic [7:0] sum);
        if (a < 25'(SIZE)) return mem[a[AW-1:0]];
`ifdef UPLOAD_CSUM_EN
        if (a == 25'(SIZE)) return sum;
`endif
        return 8'hFF;
    endfunction

    // Transaction model: session active / core halted / cycles left on the current read.
    bit            m_started = 1'b0, m_active = 1'b0, m_acked = 1'b0, m_prev = 1'b0, m_flag = 1'b0;
    bit            m_sess;
    int            m_busy = 0;
    logic [24:0]   m_addr = '0;
    logic [7:0]    m_sum = 8'h00;
    logic [7:0]    e_din = 8'h00;
    bit            e_pause = 1'b0, e_rd = 1'b0, e_done = 1'b0;
    logic [AW-1:0] e_raddr = '0;

    always @(posedge clk_sys) begin
        m_sess    = ioctl_upload && (ioctl_index == IDX);
        m_started = 1'b1;
        e_rd      = 1'b0;
        e_done    = 1'b0;
        if (RESET) begin
            m_active = 1'b0; m_acked = 1'b0; m_busy = 0; m_prev = 1'b0;
            m_flag = 1'b0; m_sum = 8'h00; e_din = 8'h00; e_pause = 1'b0; e_raddr = '0;
        end else begin
            if (!m_active) begin
                if (m_sess && !m_prev) begin
                    m_active = 1'b1; m_acked = 1'b0; m_busy = 0;
                    m_flag = 1'b0; m_sum = 8'h00; e_pause = 1'b1;
                end
            end else if (!ioctl_upload) begin
                e_done   = m_flag && (m_busy == 0);
                m_active = 1'b0; m_busy = 0; e_pause = 1'b0;
            end else if (!m_acked) begin
                m_acked = pause_ack;
            end else if (m_busy == 0) begin
                if (ioctl_rd) begin
                    m_addr = ioctl_addr;
                    if (ioctl_addr < 25'(SIZE)) begin
                        m_busy = LAT; e_rd = 1'b1; e_raddr = ioctl_addr[AW-1:0];
                    end else begin
                        m_busy = 1;
                    end
                end
            end else begin
                m_busy--;
                if (m_busy == 0) begin
                    e_din = expect_byte(m_addr, m_sum);
                    if (m_addr < 25'(SIZE)) m_sum = m_sum + e_din;
                    if (m_addr == 25'(LAST)) m_flag = 1'b1;
                end
            end
            m_prev = m_sess;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_sys) begin
        #1;
        if (m_started) begin
            chk("ioctl_din", 32'(ioctl_din), 32'(e_din));
            chk("ioctl_wait", 32'(ioctl_wait),
                32'(m_active && (!m_acked || (m_busy > 0) || ioctl_rd)));
            chk("pause_req", 32'(pause_req), 32'(e_pause));
            chk("ram_rd", 32'(ram_rd), 32'(e_rd));
            chk("ram_addr", 32'(ram_addr), 32'(e_raddr));
            chk("done", 32'(done), 32'(e_done));
        end
    end

    task automatic tick();
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
    endtask

    function automatic logic [24:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return 25'(SIZE - 1);
            1:       return 25'(SIZE);
            2:       return 25'($urandom);
            3:       return 25'h100_0000 | 25'($urandom_range(0, SIZE - 1));
            default: return 25'($urandom_range(0, SIZE - 1));
        endcase
    endfunction

    task automatic junk_strobe();
        if ($urandom_range(0, 1) == 1) begin
            ioctl_rd = 1'b1;
            ioctl_addr = rand_addr();
        end
        if ($urandom_range(0, 7) == 0) ioctl_index = 8'($urandom);
    endtask

    task automatic start(input logic [7:0] idx, input int ackdly, input bit junk);
        tick(); ioctl_upload = 1'b1; ioctl_index = idx; pause_ack = 1'b0;
        repeat (ackdly) begin tick(); if (junk) junk_strobe(); end
        tick(); pause_ack = 1'b1;
    endtask

    task automatic do_read(input logic [24:0] a, input bit junk, input int gap);
        tick(); ioctl_rd = 1'b1; ioctl_addr = a;
        tick(); if (junk) junk_strobe();
        if (a < 25'(SIZE))
            for (int k = 1; k < LAT; k++) begin tick(); if (junk) junk_strobe(); end
        repeat (gap) tick();
    endtask

    task automatic end_session();
        tick(); ioctl_upload = 1'b0; pause_ack = 1'b0;
        tick(); tick();
    endtask

    task automatic end_check_done(input bit exp);
        tick(); ioctl_upload = 1'b0; pause_ack = 1'b0;
        tick(); #2;
        chk("done_pulse", 32'(done), 32'(exp));
        chk("pause_drop", 32'(pause_req), 32'(0));
        tick(); #2;
        chk("done_once", 32'(done), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        repeat (3) tick();
        RESET = 1'b0;

        // Basic read with ack three cycles after the start.
        mem[0] = 8'h12; mem[1] = 8'h34;
        tick(); ioctl_upload = 1'b1; ioctl_index = IDX; #2;
        chk("pause_start", 32'(pause_req), 32'(0));
        tick(); #2;
        chk("pause_next", 32'(pause_req), 32'(1));
        chk("halt_wait", 32'(ioctl_wait), 32'(1));
        tick(); tick(); pause_ack = 1'b1;
        tick(); ioctl_rd = 1'b1; ioctl_addr = 25'(0); #2;
        chk("strobe_wait", 32'(ioctl_wait), 32'(1));
        tick(); #2;
        chk("ram_rd_pulse", 32'(ram_rd), 32'(1));
        tick(); tick(); #2;
        chk("byte0", 32'(ioctl_din), 32'h12);
        chk("byte0_wait", 32'(ioctl_wait), 32'(0));
        ioctl_rd = 1'b1; ioctl_addr = 25'(1);
        tick(); tick(); tick(); #2;
        chk("byte1", 32'(ioctl_din), 32'h34);
        // Abort mid-fetch keeps the last byte and gives no done.
        ioctl_rd = 1'b1; ioctl_addr = 25'(7);
        tick(); ioctl_upload = 1'b0;
        tick(); #2;
        chk("abort_din", 32'(ioctl_din), 32'h34);
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_pause", 32'(pause_req), 32'(0));
        tick(); tick();

        // Wrong index: nothing happens.
        tick(); ioctl_upload = 1'b1; ioctl_index = 8'd0; pause_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(); ioctl_rd = 1'b1; ioctl_addr = 25'($urandom_range(0, SIZE - 1)); #2;
            chk("wrongidx_wait", 32'(ioctl_wait), 32'(0));
            chk("wrongidx_pause", 32'(pause_req), 32'(0));
        end
        end_session();

        // Out-of-range address.
        start(IDX, 0, 1'b0);
        tick(); ioctl_rd = 1'b1; ioctl_addr = 25'(600);
        tick(); #2;
        chk("oor_wait", 32'(ioctl_wait), 32'(1));
        chk("oor_no_rd", 32'(ram_rd), 32'(0));
        tick(); #2;
        chk("oor_wait_low", 32'(ioctl_wait), 32'(0));
        chk("oor_byte", 32'(ioctl_din), 32'hFF);
        end_session();

        // Reset during a fetch.
        start(IDX, 1, 1'b0);
        do_read(25'(3), 1'b0, 0);
        tick(); ioctl_rd = 1'b1; ioctl_addr = 25'(9);
        tick(); RESET = 1'b1; ioctl_upload = 1'b0;
        tick(); RESET = 1'b0; #2;
        chk("rst_pause", 32'(pause_req), 32'(0));
        chk("rst_din", 32'(ioctl_din), 32'(0));
        chk("rst_ram_rd", 32'(ram_rd), 32'(0));
        chk("rst_ram_addr", 32'(ram_addr), 32'(0));
        chk("rst_wait", 32'(ioctl_wait), 32'(0));
        tick();

        // Full dump completes; one address short does not.
        for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
        start(IDX, 2, 1'b0);
        for (int a = 0; a <= LAST; a++) do_read(25'(a), 1'b0, 0);
        end_check_done(1'b1);
        start(IDX, 2, 1'b0);
        for (int a = 0; a < LAST; a++) do_read(25'(a), 1'b0, 0);
        end_check_done(1'b0);

`ifdef UPLOAD_CSUM_EN
        // Checksum of 0..255 twice is 0 mod 256; single 5 gives 5.
        for (int i = 0; i < SIZE; i++) mem[i] = 8'(i);
        start(IDX, 1, 1'b0);
        for (int a = 0; a < SIZE; a++) do_read(25'(a), 1'b0, 0);
        do_read(25'(SIZE), 1'b0, 0);
        tick(); #2;
        chk("csum_ramp", 32'(ioctl_din), 32'h00);
        end_check_done(1'b1);
        for (int i = 0; i < SIZE; i++) mem[i] = 8'h00;
        mem[0] = 8'h05;
        start(IDX, 1, 1'b0);
        for (int a = 0; a < SIZE; a++) do_read(25'(a), 1'b0, 0);
        do_read(25'(SIZE), 1'b0, 0);
        tick(); #2;
        chk("csum_five", 32'(ioctl_din), 32'h05);
        end_check_done(1'b1);
`endif

        // Randomized sessions.
        for (int s = 0; s < 25; s++) begin
            logic [7:0] idx;
            int n;
            for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
            idx = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 7)) : IDX;
            start(idx, $urandom_range(0, 4), 1'b1);
            n = $urandom_range(1, 30);
            for (int k = 0; k < n; k++) do_read(rand_addr(), 1'b1, $urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) begin
                tick(); ioctl_rd = 1'b1; ioctl_addr = 25'($urandom_range(0, SIZE - 1));
                tick(); ioctl_upload = 1'b0; pause_ack = 1'b0;
                tick(); tick();
            end else begin
                end_session();
            end
        end

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
